// File: rtl/tt_um_fir_top.sv
// tt_um_fir_top: 4-tap programmable FIR on signed 8-bit samples, Q1.7 coefs.
// Optional build macro FIR_ROUND_EN: round half up before the output shift.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   ena      design enable; all state holds while low
//   ui_in    signed sample (sample mode) or signed coefficient (load mode)
//   uio_in   [0] sample_valid, [1] coef_load, [3:2] coef index, [7:4] unused
//   uo_out   registered, scaled, saturated filter output
//   uio_out  [7] out_valid (one cycle per accepted sample), [6:0] zero
//   uio_oe   constant 8'b1000_0000
//   VPWR/VGND power pins exist only in gate-level builds (GL_TEST)

module tt_um_fir_top #(
    parameter int SHIFT      = 7,
    parameter int COEF_RESET = 32
) (
`ifdef GL_TEST
    input  wire        VPWR,
    input  wire        VGND,
`endif
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic signed [7:0] COEF_INIT = 8'(COEF_RESET);
    localparam logic signed [17:0] RND =
        18'sd1 <<< (SHIFT - 1);

    logic signed [7:0] tap  [4];
    logic signed [7:0] coef [4];

    logic              out_valid;
    logic              pend;

    logic              sample_valid;
    logic              coef_load;
    logic [1:0]        coef_idx;
    logic              do_load;
    logic              do_accept;

    logic signed [15:0] prod [4];
    logic signed [17:0] acc;
    logic signed [17:0] acc_adj;
    logic signed [17:0] y;
    logic signed [7:0]  y_sat;

    logic               unused_bits;

    assign sample_valid = uio_in[0];
    assign coef_load    = uio_in[1];
    assign coef_idx     = uio_in[3:2];
    assign unused_bits  = ^uio_in[7:4];

    // A load takes priority over the sample strobe in the same cycle.
    assign do_load   = ena & coef_load;
    assign do_accept = ena & ~coef_load & sample_valid;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            prod[k] = coef[k] * tap[k];
        end
    end

    // Four 16-bit products cannot overflow an 18-bit signed sum.
    always_comb begin
        acc = '0;
        for (int k = 0; k < 4; k++) begin
            acc = acc + {{2{prod[k][15]}}, prod[k]};
        end
    end

`ifdef FIR_ROUND_EN
    assign acc_adj = acc + RND;
`else
    assign acc_adj = acc;
    logic unused_rnd;
    assign unused_rnd = ^RND;
`endif

    assign y = acc_adj >>> SHIFT;

    always_comb begin
        y_sat = y[7:0];
        if (y > 18'sd127) begin
            y_sat = 8'sd127;
        end else if (y < -18'sd128) begin
            y_sat = -8'sd128;
        end
    end

    // Taps and coefficients.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                tap[k]  <= '0;
                coef[k] <= COEF_INIT;
            end
        end else begin
            if (do_load) begin
                coef[coef_idx] <= ui_in;
            end
            if (do_accept) begin
                tap[3] <= tap[2];
                tap[2] <= tap[1];
                tap[1] <= tap[0];
                tap[0] <= ui_in;
            end
        end
    end

    // pend marks that the taps changed on the previous enabled edge, so
    // the combinational result now reflects the new sample. It holds
    // across ena=0 cycles like all other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= 1'b0;
            out_valid <= 1'b0;
            uo_out    <= '0;
        end else if (ena) begin
            pend      <= do_accept;
            out_valid <= pend;
            if (pend) begin
                uo_out <= y_sat;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

    assign uio_out = {out_valid, 7'b0};
    assign uio_oe  = 8'b1000_0000;

endmodule

// File: tb/tb_tt_um_fir_top.sv
// tb_tt_um_fir_top: randomized and directed bench for tt_um_fir_top
// with a queue-free arithmetic reference model of the FIR.

module tb_tt_um_fir_top;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks;
    int n_fail;

    // Reference model state (plain integers).
    int  m_x [4];
    int  m_c [4];
    bit  m_pend;
    int  m_pval;
    int  m_uo;
    bit  m_valid;

    tt_um_fir_top dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int fir_ref();
        int acc;
        int y;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            acc += m_c[k] * m_x[k];
        end
`ifdef FIR_ROUND_EN
        acc += 64;
`endif
        // floor division by 128
        y = (acc >= 0) ? acc / 128 : -((-acc + 127) / 128);
        if (y > 127) y = 127;
        if (y < -128) y = -128;
        return y;
    endfunction

    function automatic int s8(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_x[k] = 0;
            m_c[k] = 32;
        end
        m_pend  = 0;
        m_pval  = 0;
        m_uo    = 0;
        m_valid = 0;
    endtask

    // Drive one cycle, advance the model, land 1 ns after the edge.
    task automatic step(input bit e, input bit sv, input bit ld,
                        input logic [1:0] idx, input logic [7:0] d);
        ena    = e;
        uio_in = {4'h0, idx, ld, sv};
        ui_in  = d;
        @(posedge clk);
        if (e) begin
            m_valid = m_pend;
            if (m_pend) m_uo = m_pval;
            m_pend = 0;
            if (ld) begin
                m_c[idx] = s8(d);
            end else if (sv) begin
                m_x[3] = m_x[2];
                m_x[2] = m_x[1];
                m_x[1] = m_x[0];
                m_x[0] = s8(d);
                m_pend = 1;
                m_pval = fir_ref();
            end
        end else begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = '0;
        uio_in = '0;
        model_reset();
        #12;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (uo_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_uo got=%h exp=00", uo_out);
        end
        n_checks++;
        if (uio_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_uio_out got=%h exp=00", uio_out);
        end
        n_checks++;
        if (uio_oe !== 8'h80) begin
            n_fail++;
            $display("FAIL reset_oe got=%h exp=80", uio_oe);
        end
    endtask

    task automatic test_dc();
        int exp_v [4] = '{25, 50, 75, 100};
        step(1, 1, 0, 2'd0, 8'd100);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) step(1, 1, 0, 2'd0, 8'd100);
            else       step(1, 0, 0, 2'd0, 8'd0);
            n_checks++;
            if (uio_out !== 8'h80 || s8(uo_out) != exp_v[i]) begin
                n_fail++;
                $display("FAIL dc_%0d got=%0d/%h exp=%0d/80",
                         i, s8(uo_out), uio_out, exp_v[i]);
            end
        end
        step(1, 0, 0, 2'd0, 8'd0);
        n_checks++;
        if (uio_out !== 8'h00 || s8(uo_out) != 100) begin
            n_fail++;
            $display("FAIL dc_hold got=%0d/%h exp=100/00",
                     s8(uo_out), uio_out);
        end
    endtask

    task automatic test_impulse();
        logic [7:0] cf [4] = '{8'd64, 8'hC0, 8'd32, 8'd16};
        logic [7:0] xs [4] = '{8'd127, 8'd0, 8'd0, 8'd0};
`ifdef FIR_ROUND_EN
        int exp_v [4] = '{64, -63, 32, 16};
`else
        int exp_v [4] = '{63, -64, 31, 15};
`endif
        for (int k = 0; k < 4; k++) step(1, 0, 1, 2'(k), cf[k]);
        // flush the old taps so the impulse starts from zeros
        for (int k = 0; k < 4; k++) step(1, 1, 0, 2'd0, 8'd0);
        step(1, 0, 0, 2'd0, 8'd0);
        step(1, 1, 0, 2'd0, xs[0]);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) step(1, 1, 0, 2'd0, xs[i+1]);
            else       step(1, 0, 0, 2'd0, 8'd0);
            n_checks++;
            if (uio_out !== 8'h80 || s8(uo_out) != exp_v[i]) begin
                n_fail++;
                $display("FAIL impulse_%0d got=%0d/%h exp=%0d/80",
                         i, s8(uo_out), uio_out, exp_v[i]);
            end
        end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 4; k++) step(1, 0, 1, 2'(k), 8'd127);
        for (int k = 0; k < 4; k++) step(1, 1, 0, 2'd0, 8'd127);
        step(1, 0, 0, 2'd0, 8'd0);
        n_checks++;
        if (s8(uo_out) != 127 || uio_out !== 8'h80) begin
            n_fail++;
            $display("FAIL sat_pos got=%0d exp=127", s8(uo_out));
        end
        for (int k = 0; k < 4; k++) step(1, 1, 0, 2'd0, 8'h80);
        step(1, 0, 0, 2'd0, 8'd0);
        n_checks++;
        if (s8(uo_out) != -128 || uio_out !== 8'h80) begin
            n_fail++;
            $display("FAIL sat_neg got=%0d exp=-128", s8(uo_out));
        end
    endtask

    task automatic test_load_priority();
        step(1, 0, 0, 2'd0, 8'd0);
        step(1, 1, 1, 2'd2, 8'd77);
        step(1, 0, 0, 2'd0, 8'd0);
        n_checks++;
        if (uio_out[7] !== 1'b0) begin
            n_fail++;
            $display("FAIL load_prio_valid got=%b exp=0", uio_out[7]);
        end
        // a fresh sample reveals both the kept taps and the new coef
        step(1, 1, 0, 2'd0, 8'd10);
        step(1, 0, 0, 2'd0, 8'd0);
        n_checks++;
        if (s8(uo_out) != m_uo || uio_out[7] !== 1'b1) begin
            n_fail++;
            $display("FAIL load_prio_taps got=%0d/%b exp=%0d/1",
                     s8(uo_out), uio_out[7], m_uo);
        end
    endtask

    task automatic test_ena();
        logic [7:0] held;
        step(1, 0, 0, 2'd0, 8'd0);
        held = uo_out;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 2'd0, 8'($urandom));
            n_checks++;
            if (uo_out !== held || uio_out[7] !== 1'b0) begin
                n_fail++;
                $display("FAIL ena_hold_%0d got=%h/%b exp=%h/0",
                         i, uo_out, uio_out[7], held);
            end
        end
        step(1, 1, 0, 2'd0, 8'd40);
        step(1, 0, 0, 2'd0, 8'd0);
        n_checks++;
        if (s8(uo_out) != m_uo || uio_out[7] !== 1'b1) begin
            n_fail++;
            $display("FAIL ena_resume got=%0d/%b exp=%0d/1",
                     s8(uo_out), uio_out[7], m_uo);
        end
    endtask

    task automatic test_random();
        bit e, sv, ld;
        for (int i = 0; i < 300; i++) begin
            e  = ($urandom_range(0, 99) < 85);
            sv = ($urandom_range(0, 99) < 60);
            ld = ($urandom_range(0, 99) < 15);
            step(e, sv, ld, 2'($urandom), 8'($urandom));
            n_checks++;
            if (s8(uo_out) != m_uo || uio_out !== {m_valid, 7'b0}) begin
                n_fail++;
                $display("FAIL rand_%0d got=%0d/%h exp=%0d/%h",
                         i, s8(uo_out), uio_out, m_uo,
                         {m_valid, 7'b0});
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1, 1, 0, 2'd0, 8'd90);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h80)
        begin
            n_fail++;
            $display("FAIL reset_mid got=%h/%h/%h exp=00/00/80",
                     uo_out, uio_out, uio_oe);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 0, 2'd0, 8'd100);
        step(1, 0, 0, 2'd0, 8'd0);
        n_checks++;
        if (s8(uo_out) != 25 || uio_out !== 8'h80) begin
            n_fail++;
            $display("FAIL reset_mid_coef got=%0d/%h exp=25/80",
                     s8(uo_out), uio_out);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_dc();
        test_impulse();
        test_saturate();
        test_load_priority();
        test_ena();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
